seg7_scan: RTL and testbench

- Consumes the CPU's 32-bit `display_7segs` word and drives an 8-digit multiplexed seven-segment display (digit anodes plus segment lines).
- Time-multiplexes one hex nibble per digit slot using a prescaled refresh tick.
- Snapshots the input once per frame so a frame never shows a torn value.
- Optionally blanks leading zeros.
- Sits at board top level, between `CPU.display_7segs` and the FPGA display pins.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 30 +++
 rtl/seg7_scan.sv | 121 ++++++++++++
 tb/tb_seg7_scan.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: digit count
// and the active-high hex-to-segment table (bit order gfedcba).
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF_AH = 7'h00;

    // Entry 15 first: the concatenation fills the packed array from the top index down.
    localparam logic [15:0][6:0] HEX_SEG_AH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg_ah(input logic [3:0] nibble);
        return HEX_SEG_AH[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with blanking and selectable pin
// polarity; feeds the registered segment outputs of seg7_scan.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_ah_s;

    // Select the lit pattern, then apply the board's pin polarity.
    always_comb begin
        seg_ah_s = SEG_OFF_AH;
        if (blank) begin
            seg_ah_s = SEG_OFF_AH;
        end else begin
            seg_ah_s = hex_to_seg_ah(nibble);
        end
        if (ACTIVE_LOW) begin
            seg = ~seg_ah_s;
        end else begin
            seg = seg_ah_s;
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver: prescaled digit scan, a
// per-frame snapshot of the CPU word, optional leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIV_WIDTH  = 17,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value_in,
    input  logic        blank_lz,
    input  logic        hold,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [7:0] AN_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DIV_WIDTH-1:0] PRESC_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] prescaler_r;
    logic [2:0]           digit_idx_r;
    logic [31:0]          snapshot_r;
    logic                 frame_done_r;
    logic [7:0]           an_r;
    logic [6:0]           seg_r;
    logic                 dp_r;

    logic                 tick_s;
    logic                 frame_end_s;
    logic [3:0]           nibble_s;
    logic [31:0]          upper_s;
    logic                 blank_s;
    logic [7:0]           onehot_s;
    logic [7:0]           an_next_s;
    logic [6:0]           seg_next_s;

    // Slot timing and the blanking test for the digit currently being scanned.
    always_comb begin
        tick_s      = &prescaler_r;
        frame_end_s = tick_s && (digit_idx_r == 3'(NUM_DIGITS - 1));
        nibble_s    = snapshot_r[{digit_idx_r, 2'b00} +: 4];
        upper_s     = snapshot_r >> {digit_idx_r, 2'b00};
        onehot_s    = 8'h01 << digit_idx_r;
        blank_s     = 1'b0;
        if (blank_lz && (digit_idx_r != 3'd0) && (upper_s == 32'h0000_0000)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
        an_next_s = 8'h00;
        if (blank_s) begin
            an_next_s = AN_OFF;
        end else if (ACTIVE_LOW) begin
            an_next_s = ~onehot_s;
        end else begin
            an_next_s = onehot_s;
        end
    end

    seg7_hex_decode #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .nibble (nibble_s),
        .blank  (blank_s),
        .seg    (seg_next_s)
    );

    // Free-running prescaler and digit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_r <= '0;
            digit_idx_r <= 3'd0;
        end else begin
            prescaler_r <= prescaler_r + PRESC_ONE;
            if (tick_s) begin
                digit_idx_r <= digit_idx_r + 3'd1;
            end else begin
                digit_idx_r <= digit_idx_r;
            end
        end
    end

    // Frame-boundary snapshot keeps a frame from mixing two CPU values.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot_r   <= 32'h0000_0000;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_end_s;
            if (frame_end_s && !hold) begin
                snapshot_r <= value_in;
            end else begin
                snapshot_r <= snapshot_r;
            end
        end
    end

    // Registered pin drivers, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
            dp_r  <= DP_OFF;
        end else begin
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
            dp_r  <= DP_OFF;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (DIV_WIDTH=2, active-low pins): stimulus
// queues per-cycle expectations, a monitor compares them on the falling edge.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value_in;
    logic        blank_lz;
    logic        hold;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan #(
        .DIV_WIDTH  (2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .blank_lz   (blank_lz),
        .hold       (hold),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
        string      tag;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Active-low pin codes for hex digits 0..F, worked out by hand.
    logic [6:0] seg_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Monitor: one expectation per clock, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (an !== e.an || seg !== e.seg || dp !== 1'b1 || frame_done !== e.fd) begin
                    bad++;
                    $display("FAIL %s[%0d]: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=1 fd=%b",
                             e.tag, e.idx, an, seg, dp, frame_done, e.an, e.seg, e.fd);
                end
            end
        end
    end

    // One 32-cycle frame showing snap; optional value change or reset at a given cycle.
    task automatic frame(input logic [31:0] snap, input string tag, input int chg_at,
                         input logic [31:0] chg_val, input int rst_at);
        exp_t        e;
        int          d;
        logic        blk;
        logic [31:0] up;
        for (int i = 0; i < 32; i++) begin
            if (i == chg_at) value_in = chg_val;
            if (i == rst_at) rst = 1'b1;
            @(posedge clk);
            d   = i / 4;
            up  = snap >> (4 * d);
            blk = blank_lz && (d != 0) && (up == 32'h0);
            e.tag = tag;
            e.idx = i;
            if (i == rst_at) begin
                e.an  = 8'hFF;
                e.seg = 7'h7F;
                e.fd  = 1'b0;
            end else begin
                e.an  = blk ? 8'hFF : ~(8'h01 << d);
                e.seg = blk ? 7'h7F : seg_al[snap[4*d +: 4]];
                e.fd  = (i == 31);
            end
            exp_q.push_back(e);
            #1;
            if (i == rst_at) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        exp_t r;
        rst      = 1'b1;
        blank_lz = 1'b0;
        hold     = 1'b0;
        value_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            r.an  = 8'hFF;
            r.seg = 7'h7F;
            r.fd  = 1'b0;
            r.tag = "reset";
            r.idx = i;
            exp_q.push_back(r);
        end
        #1;
        rst      = 1'b0;
        value_in = 32'h1234_5678;

        frame(32'h0000_0000, "frame0",     -1, 32'h0,          -1);
        frame(32'h1234_5678, "scan",       13, 32'hDEAD_BEEF,  -1);
        frame(32'hDEAD_BEEF, "newval",      0, 32'h0000_00A5,  -1);
        blank_lz = 1'b1;
        frame(32'h0000_00A5, "blank_a5",    0, 32'h0000_0000,  -1);
        frame(32'h0000_0000, "blank_zero",  0, 32'h89AB_CDEF,  -1);
        blank_lz = 1'b0;
        hold     = 1'b1;
        frame(32'h89AB_CDEF, "hold1",       5, 32'h1111_1111,  -1);
        frame(32'h89AB_CDEF, "hold2",       7, 32'h2222_2222,  -1);
        hold     = 1'b0;
        frame(32'h89AB_CDEF, "release",    -1, 32'h0,          -1);
        frame(32'h2222_2222, "mid_rst",    -1, 32'h0,          21);
        frame(32'h0000_0000, "post_rst",   -1, 32'h0,          -1);

        @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
